bcast_reg: RTL and testbench



---
 rtl/bcast_reg.sv | 83 ++++++++
 tb/tb_bcast_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcast_reg.sv
// Registered two-way stream broadcast. Each accepted input item is held in
// one output register per branch and delivered exactly once on each branch.
// A new item is taken only when both branches can take it, so the branches
// never drift apart by more than one item.
module bcast_reg #(
  parameter int TDIN   = 16,
  parameter bit EOT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TDIN-1:0] din_data,
  input  logic            din_eot,
  input  logic            din_dvalid,
  output logic            din_dready,
  output logic [TDIN-1:0] dout0_data,
  output logic            dout0_eot,
  output logic            dout0_dvalid,
  input  logic            dout0_dready,
  output logic [TDIN-1:0] dout1_data,
  output logic            dout1_eot,
  output logic            dout1_dvalid,
  input  logic            dout1_dready
);

  logic            full0, full1;
  logic [TDIN-1:0] data0, data1;
  logic            eot0, eot1;
  logic            hs0, hs1;
  logic            free0, free1;
  logic            acc;

  // Branch handshakes, per-branch space and the shared input ready.
  // Ready never looks at din_dvalid so no valid->ready loop can form.
  always_comb begin
    hs0        = full0 & dout0_dready;
    hs1        = full1 & dout1_dready;
    free0      = ~full0 | hs0;
    free1      = ~full1 | hs1;
    din_dready = free0 & free1;
    acc        = din_dvalid & din_dready;
  end

  // Branch 0 register: reload on accept (even while draining), else empty on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      full0 <= 1'b0;
      data0 <= '0;
      eot0  <= 1'b0;
    end else if (acc) begin
      full0 <= 1'b1;
      data0 <= din_data;
      eot0  <= din_eot;
    end else if (hs0) begin
      full0 <= 1'b0;
    end
  end

  // Branch 1 register: same rules as branch 0, driven by its own handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      full1 <= 1'b0;
      data1 <= '0;
      eot1  <= 1'b0;
    end else if (acc) begin
      full1 <= 1'b1;
      data1 <= din_data;
      eot1  <= din_eot;
    end else if (hs1) begin
      full1 <= 1'b0;
    end
  end

  // Outputs come straight from the branch registers; eot is masked when not carried.
  always_comb begin
    dout0_dvalid = full0;
    dout0_data   = data0;
    dout0_eot    = eot0 & EOT_EN;
    dout1_dvalid = full1;
    dout1_data   = data1;
    dout1_eot    = eot1 & EOT_EN;
  end

endmodule

// File: tb/tb_bcast_reg.sv
// Bench for bcast_reg: a queue-based model of each branch checked every cycle,
// directed scenarios with literal expectations, and two extra builds for
// width extremes and disabled eot.
module tb_bcast_reg;

  logic        clk;
  logic        rst;
  logic [15:0] din_data;
  logic        din_eot, din_dvalid, din_dready;
  logic [15:0] dout0_data, dout1_data;
  logic        dout0_eot, dout0_dvalid, dout0_dready;
  logic        dout1_eot, dout1_dvalid, dout1_dready;

  logic [63:0] w_din_data, w_dout0_data, w_dout1_data;
  logic        w_din_eot, w_din_dvalid, w_din_dready;
  logic        w_dout0_eot, w_dout0_dvalid, w_dout1_eot, w_dout1_dvalid;

  logic        n_din_data, n_dout0_data, n_dout1_data;
  logic        n_din_eot, n_din_dvalid, n_din_dready;
  logic        n_dout0_eot, n_dout0_dvalid, n_dout1_eot, n_dout1_dvalid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcast_reg #(.TDIN(16), .EOT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_eot(din_eot), .din_dvalid(din_dvalid), .din_dready(din_dready),
    .dout0_data(dout0_data), .dout0_eot(dout0_eot), .dout0_dvalid(dout0_dvalid), .dout0_dready(dout0_dready),
    .dout1_data(dout1_data), .dout1_eot(dout1_eot), .dout1_dvalid(dout1_dvalid), .dout1_dready(dout1_dready)
  );

  bcast_reg #(.TDIN(64), .EOT_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst),
    .din_data(w_din_data), .din_eot(w_din_eot), .din_dvalid(w_din_dvalid), .din_dready(w_din_dready),
    .dout0_data(w_dout0_data), .dout0_eot(w_dout0_eot), .dout0_dvalid(w_dout0_dvalid), .dout0_dready(1'b1),
    .dout1_data(w_dout1_data), .dout1_eot(w_dout1_eot), .dout1_dvalid(w_dout1_dvalid), .dout1_dready(1'b1)
  );

  bcast_reg #(.TDIN(1), .EOT_EN(1'b1)) dut_n (
    .clk(clk), .rst(rst),
    .din_data(n_din_data), .din_eot(n_din_eot), .din_dvalid(n_din_dvalid), .din_dready(n_din_dready),
    .dout0_data(n_dout0_data), .dout0_eot(n_dout0_eot), .dout0_dvalid(n_dout0_dvalid), .dout0_dready(1'b1),
    .dout1_data(n_dout1_data), .dout1_eot(n_dout1_eot), .dout1_dvalid(n_dout1_dvalid), .dout1_dready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: each branch holds the items accepted but not yet delivered
  // ({eot,data}); the visible data is the last accepted value (0 after reset).
  logic [16:0] q0[$], q1[$];
  logic [16:0] del0[$], del1[$];
  int          dc0[$], dc1[$];
  logic [16:0] last0 = '0, last1 = '0;

  always @(negedge clk) begin
    logic exp_rdy;
    logic [16:0] item;
    cyc++;
    exp_rdy = (q0.size() == 0 || dout0_dready) && (q1.size() == 0 || dout1_dready);
    chk("dvalid0", 64'(dout0_dvalid), 64'(q0.size() != 0));
    chk("dvalid1", 64'(dout1_dvalid), 64'(q1.size() != 0));
    chk("data0",   64'(dout0_data),   64'(last0[15:0]));
    chk("data1",   64'(dout1_data),   64'(last1[15:0]));
    chk("eot0",    64'(dout0_eot),    64'(last0[16]));
    chk("eot1",    64'(dout1_eot),    64'(last1[16]));
    chk("din_dready", 64'(din_dready), 64'(exp_rdy));
    if (rst) begin
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
    end else begin
      if (q0.size() != 0 && dout0_dready) begin
        item = q0.pop_front();
        del0.push_back(item);
        dc0.push_back(cyc);
      end
      if (q1.size() != 0 && dout1_dready) begin
        item = q1.pop_front();
        del1.push_back(item);
        dc1.push_back(cyc);
      end
      if (din_dvalid && exp_rdy) begin
        item = {din_eot, din_data};
        q0.push_back(item);
        q1.push_back(item);
        last0 = item;
        last1 = item;
      end
    end
  end

  initial begin
    int n;
    int guard;
    int eots;
    logic [63:0] wexp;
    rst = 1'b1;
    din_data = '0; din_eot = 1'b0; din_dvalid = 1'b0;
    dout0_dready = 1'b0; dout1_dready = 1'b0;
    w_din_data = '0; w_din_eot = 1'b0; w_din_dvalid = 1'b0;
    n_din_data = 1'b0; n_din_eot = 1'b0; n_din_dvalid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_dready", 64'(din_dready), 64'd1);
    chk("rst_dvalid0", 64'(dout0_dvalid), 64'd0);
    chk("rst_data1", 64'(dout1_data), 64'd0);

    // Back-to-back stream, both branches always ready.
    del0.delete(); del1.delete(); dc0.delete(); dc1.delete();
    dout0_dready = 1'b1; dout1_dready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      din_dvalid = 1'b1;
      din_data   = 16'(i);
      din_eot    = (i == 16);
      step();
    end
    din_dvalid = 1'b0; din_eot = 1'b0;
    repeat (2) step();
    chk("t1_cnt0", 64'(del0.size()), 64'd16);
    chk("t1_cnt1", 64'(del1.size()), 64'd16);
    if (del0.size() == 16 && del1.size() == 16) begin
      chk("t1_first", 64'(del0[0]), 64'h00001);
      chk("t1_last",  64'(del1[15]), 64'h10010);
      chk("t1_nobubble", 64'(dc0[15] - dc0[0]), 64'd15);
      eots = 0;
      foreach (del0[i]) eots += int'(del0[i][16]);
      chk("t1_eotcnt", 64'(eots), 64'd1);
    end

    // Slow branch 1 holds its item; input stalls until it drains.
    del0.delete(); del1.delete();
    dout0_dready = 1'b1; dout1_dready = 1'b0;
    din_dvalid = 1'b1; din_data = 16'hAAAA;
    step();
    chk("t2_d0_first", 64'({dout0_dvalid, dout0_data}), 64'h1AAAA);
    chk("t2_d1_first", 64'({dout1_dvalid, dout1_data}), 64'h1AAAA);
    chk("t2_rdy_first", 64'(din_dready), 64'd0);
    din_data = 16'hBBBB;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("t2_d0_idle", 64'(dout0_dvalid), 64'd0);
      chk("t2_d1_hold", 64'({dout1_dvalid, dout1_data}), 64'h1AAAA);
      chk("t2_rdy_low", 64'(din_dready), 64'd0);
    end
    dout1_dready = 1'b1;
    #1;
    chk("t2_rdy_release", 64'(din_dready), 64'd1);
    step();
    chk("t2_d0_b", 64'({dout0_dvalid, dout0_data}), 64'h1BBBB);
    chk("t2_d1_b", 64'({dout1_dvalid, dout1_data}), 64'h1BBBB);
    din_dvalid = 1'b0;
    step();
    chk("t2_cnt0", 64'(del0.size()), 64'd2);
    chk("t2_cnt1", 64'(del1.size()), 64'd2);
    if (del1.size() == 2) begin
      chk("t2_del1_0", 64'(del1[0]), 64'h0AAAA);
      chk("t2_del1_1", 64'(del1[1]), 64'h0BBBB);
    end

    // Random readies and valid, 1000 items.
    del0.delete(); del1.delete();
    n = 0; guard = 0;
    while (n < 1000 && guard < 20000) begin
      dout0_dready = 1'($urandom % 2);
      dout1_dready = 1'($urandom % 2);
      din_dvalid   = 1'($urandom % 2);
      din_data     = n[15:0];
      din_eot      = (n == 999);
      #1;
      if (din_dvalid && din_dready) n++;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("t3_sent", 64'(n), 64'd1000);
    din_dvalid = 1'b0; din_eot = 1'b0;
    dout0_dready = 1'b1; dout1_dready = 1'b1;
    repeat (3) step();
    chk("t3_cnt0", 64'(del0.size()), 64'd1000);
    chk("t3_cnt1", 64'(del1.size()), 64'd1000);
    if (del0.size() == 1000 && del1.size() == 1000) begin
      chk("t3_last0", 64'(del0[999]), 64'h103E7);
      chk("t3_mid1",  64'(del1[500]), 64'h001F4);
    end

    // Reset while both branches hold an undelivered item.
    del0.delete(); del1.delete();
    dout0_dready = 1'b0; dout1_dready = 1'b0;
    din_dvalid = 1'b1; din_data = 16'h1234;
    step();
    din_dvalid = 1'b0;
    step();
    chk("t4_full0", 64'({dout0_dvalid, dout0_data}), 64'h11234);
    chk("t4_full1", 64'({dout1_dvalid, dout1_data}), 64'h11234);
    rst = 1'b1; din_dvalid = 1'b1; din_data = 16'h9999;
    step();
    chk("t4_rst0", 64'({dout0_dvalid, dout0_data}), 64'h00000);
    chk("t4_rst1", 64'({dout1_dvalid, dout1_data}), 64'h00000);
    rst = 1'b0; din_data = 16'h5678;
    #1;
    chk("t4_rdy_after", 64'(din_dready), 64'd1);
    step();
    chk("t4_new0", 64'({dout0_dvalid, dout0_data}), 64'h15678);
    chk("t4_new1", 64'({dout1_dvalid, dout1_data}), 64'h15678);
    din_dvalid = 1'b0;
    dout0_dready = 1'b1; dout1_dready = 1'b1;
    step();
    chk("t4_cnt0", 64'(del0.size()), 64'd1);
    chk("t4_cnt1", 64'(del1.size()), 64'd1);
    if (del0.size() == 1) chk("t4_only", 64'(del0[0]), 64'h05678);

    // Width extremes and eot disabled.
    for (int i = 0; i < 8; i++) begin
      wexp = (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      w_din_dvalid = 1'b1; w_din_eot = 1'b1; w_din_data = wexp;
      n_din_dvalid = 1'b1; n_din_eot = (i == 7); n_din_data = 1'(i % 2);
      step();
      chk("w_rdy",  64'(w_din_dready), 64'd1);
      chk("w_out0", {w_dout0_data}, wexp);
      chk("w_out1", {w_dout1_data}, wexp);
      chk("w_ctl",  64'({w_dout0_dvalid, w_dout0_eot, w_dout1_dvalid, w_dout1_eot}), 64'b1010);
      chk("n_out",  64'({n_dout0_dvalid, n_dout0_data, n_dout1_dvalid, n_dout1_data}),
          (i % 2 == 1) ? 64'b1111 : 64'b1010);
      chk("n_eot",  64'({n_dout0_eot, n_dout1_eot}), (i == 7) ? 64'b11 : 64'b00);
    end
    w_din_dvalid = 1'b0; n_din_dvalid = 1'b0;
    step();
    chk("w_idle", 64'({w_dout0_dvalid, w_dout1_dvalid, n_dout0_dvalid}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
